// File: rtl/ff_conv_pkg.sv
// Shared definitions for the flip-flop conversion library: core selection
// and the per-bit input mapping that turns a JK/SR/T core into a D-type.
package ff_conv_pkg;

  typedef enum logic [1:0] {
    CORE_JK = 2'd0,
    CORE_SR = 2'd1,
    CORE_T  = 2'd2
  } core_e;

  // Returns {a, b} core drive bits so that the core's next state equals d.
  // For the T core only a is meaningful; b is tied low.
  function automatic logic [1:0] map_inputs(core_e core, logic d, logic q);
    logic [1:0] drv;
    case (core)
      CORE_T:  drv = {d ^ q, 1'b0};
      default: drv = {d, ~d};
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/ff_core.sv
// One bit of JK, SR or T storage with asynchronous active-high reset.
// Inputs: a/b = J/K or S/R; for the T core a is T and b is ignored.
module ff_core
  import ff_conv_pkg::*;
#(
  parameter core_e CORE = CORE_JK
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic q
);

  generate
    if (CORE == CORE_T) begin : g_t
      logic unused_b;
      assign unused_b = b;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)    q <= 1'b0;
        else if (a) q <= ~q;
      end
    end else if (CORE == CORE_SR) begin : g_sr
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= 1'b0;
        end else begin
          // S=R=1 is illegal: hold the bit and flag it in simulation.
          assert (!(a && b));
          case ({a, b})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            default: q <= q;
          endcase
        end
      end
    end else begin : g_jk
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= 1'b0;
        end else begin
          case ({a, b})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: rtl/cd_d_from_jk.sv
// D flip-flop built from a JK, SR or T core plus input-mapping logic;
// externally identical to a WIDTH-bit DFF with asynchronous reset.
module cd_d_from_jk
  import ff_conv_pkg::*;
#(
  parameter int    WIDTH = 1,
  parameter string CORE  = "JK"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam bit CORE_OK = (CORE == "JK") || (CORE == "SR") || (CORE == "T");

  localparam core_e CORE_SEL = (CORE == "SR") ? CORE_SR :
                               (CORE == "T")  ? CORE_T  : CORE_JK;

  generate
    if (!CORE_OK) begin : g_bad_core
      $error("cd_d_from_jk: unsupported CORE value '%s'", CORE);
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      logic [1:0] drv;

      // T core needs its own state fed back to derive the toggle enable.
      assign drv = map_inputs(CORE_SEL, d[i], q[i]);

      ff_core #(
        .CORE(CORE_SEL)
      ) u_core (
        .clk(clk),
        .rst(rst),
        .a  (drv[1]),
        .b  (drv[0]),
        .q  (q[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_cd_d_from_jk.sv
// Bench for cd_d_from_jk: all three cores at WIDTH 1 and 4, checked against
// a plain DFF reference (q = 0 under reset, else d sampled at each edge).
module tb_cd_d_from_jk;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d   = 4'h0;

  logic [3:0] q_jk4, q_sr4, q_t4;
  logic       q_jk1, q_sr1, q_t1;

  logic [3:0] q_ref;
  logic [3:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cd_d_from_jk #(.WIDTH(4), .CORE("JK")) u_jk4 (.clk(clk), .rst(rst), .d(d),    .q(q_jk4));
  cd_d_from_jk #(.WIDTH(4), .CORE("SR")) u_sr4 (.clk(clk), .rst(rst), .d(d),    .q(q_sr4));
  cd_d_from_jk #(.WIDTH(4), .CORE("T"))  u_t4  (.clk(clk), .rst(rst), .d(d),    .q(q_t4));
  cd_d_from_jk #(.WIDTH(1), .CORE("JK")) u_jk1 (.clk(clk), .rst(rst), .d(d[0]), .q(q_jk1));
  cd_d_from_jk #(.WIDTH(1), .CORE("SR")) u_sr1 (.clk(clk), .rst(rst), .d(d[0]), .q(q_sr1));
  cd_d_from_jk #(.WIDTH(1), .CORE("T"))  u_t1  (.clk(clk), .rst(rst), .d(d[0]), .q(q_t1));

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, "/jk4"}, q_jk4, q_ref);
    check_val({tag, "/sr4"}, q_sr4, q_ref);
    check_val({tag, "/t4"},  q_t4,  q_ref);
    check_val({tag, "/jk1"}, {3'b000, q_jk1}, {3'b000, q_ref[0]});
    check_val({tag, "/sr1"}, {3'b000, q_sr1}, {3'b000, q_ref[0]});
    check_val({tag, "/t1"},  {3'b000, q_t1},  {3'b000, q_ref[0]});
  endtask

  // One rising edge: record what a plain DFF would capture, then compare.
  task automatic tick(input string tag);
    @(posedge clk);
    exp_q.push_back(rst ? 4'h0 : d);
    #1;
    q_ref = exp_q.pop_front();
    check_all(tag);
  endtask

  task automatic set_d(input logic [3:0] v);
    @(negedge clk);
    d = v;
  endtask

  // Reset pulse strictly between edges; the following edge loads d again.
  task automatic pulse_rst_mid();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    q_ref = 4'h0;
    check_all("rst_mid_assert");
    #1 rst = 1'b0;
    #1 check_all("rst_mid_release");
  endtask

  initial begin
    // Reset held from time zero.
    #2;
    q_ref = 4'h0;
    check_all("reset_initial");

    // Reset held while d toggles: q stays 0.
    for (int i = 0; i < 3; i++) begin
      set_d((i % 2 == 0) ? 4'hF : 4'h0);
      tick("reset_hold");
    end

    // Release with d=1: no change until the next edge, then q=1.
    @(negedge clk);
    d   = 4'hF;
    rst = 1'b0;
    #1 check_all("release_no_change");
    tick("release_first_edge");

    // d=0 on the next edge clears q.
    set_d(4'h0);
    tick("load_zero");

    // q=1, then a mid-cycle reset clears it immediately.
    set_d(4'hF);
    tick("load_one");
    pulse_rst_mid();
    tick("after_mid_reset");

    // Glitches between edges: only the value at the edge counts.
    @(negedge clk);
    d = 4'h0; #1 d = 4'hF; #1 d = 4'h0; #1 d = 4'hF;
    tick("glitch_to_one");
    @(negedge clk);
    d = 4'hF; #1 d = 4'h0; #1 d = 4'hF; #1 d = 4'h0;
    tick("glitch_to_zero");

    // Alternating patterns on consecutive edges.
    set_d(4'b1010);
    tick("pattern_1010");
    set_d(4'b0101);
    tick("pattern_0101");

    // Reset asserted at the same instant as a clock edge wins.
    set_d(4'hF);
    @(posedge clk);
    rst = 1'b1;
    #1;
    q_ref = 4'h0;
    check_all("rst_at_edge");
    @(negedge clk);
    rst = 1'b0;
    #1 check_all("rst_at_edge_release");
    tick("rst_at_edge_reload");

    // Randomized traffic with occasional reset pulses and d glitches.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        pulse_rst_mid();
        tick("rand_after_rst");
      end else begin
        set_d(4'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) == 0) #2 d = 4'($urandom_range(0, 15));
        tick("rand_edge");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
